// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states and
// architectural constants.
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    // op[1] selects divide, op[0] selects signed operation.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Start/busy/done handshake and hi/lo result bus between the control unit and mdu_iter.
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negation; used for operand magnitudes and result sign fix-up.
module mdu_signfix #(
    parameter int unsigned W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider with start/busy/done handshake.
// Optional MDU_EARLY_TERM_EN: zero-operand multiplies and divide-by-zero skip CALC and FIX.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic       clk,
    input logic       rst_n,
    mdu_iter_if.slave bus
);

    mdu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_opa;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_sa;
    logic               w_sb;
    logic               w_is_div;
    logic               w_accept;
    logic               w_early;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_is_div = op_is_div(bus.op);
    assign w_sa     = op_is_signed(bus.op) & bus.a[WIDTH-1];
    assign w_sb     = op_is_signed(bus.op) & bus.b[WIDTH-1];
    // The done cycle sits in IDLE with busy still high; a start there must not be taken.
    assign w_accept = (r_state == IDLE) && bus.start && !r_busy;

`ifdef MDU_EARLY_TERM_EN
    assign w_early = w_is_div ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0));
`else
    assign w_early = 1'b0;
`endif

    mdu_signfix #(.W(WIDTH)) u_mag_a (.i_neg(w_sa), .i_val(bus.a), .o_val(w_mag_a));
    mdu_signfix #(.W(WIDTH)) u_mag_b (.i_neg(w_sb), .i_val(bus.b), .o_val(w_mag_b));

    // Multiply: r_acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: r_acc = {partial remainder, dividend bits shifting out / quotient bits in}.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_opa};
    assign w_ge       = (w_shift >= {1'b0, r_opa});
    assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    mdu_signfix #(.W(2*WIDTH)) u_fix_prod (.i_neg(r_neg_q), .i_val(r_acc), .o_val(w_prod_fix));
    mdu_signfix #(.W(WIDTH)) u_fix_quot (
        .i_neg(r_neg_q),
        .i_val(r_acc[WIDTH-1:0]),
        .o_val(w_quot_fix)
    );
    mdu_signfix #(.W(WIDTH)) u_fix_rem (
        .i_neg(r_neg_r),
        .i_val(r_acc[2*WIDTH-1:WIDTH]),
        .o_val(w_rem_fix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_a_raw  <= '0;
            r_opa    <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            // Handshake outputs trail the state by one cycle.
            r_busy <= (r_state != IDLE);
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_div <= w_is_div;
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_div0   <= w_is_div && (bus.b == '0);
                        r_a_raw  <= bus.a;
                        r_opa    <= w_is_div ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        r_cnt    <= '0;
                        if (w_early) begin
                            r_hi    <= w_is_div ? bus.a : '0;
                            r_lo    <= w_is_div ? '1 : '0;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc <= r_op_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!r_op_div) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_div0) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the single-cycle datapath.
- Sits directly upstream of the 4-input writeback select mux and drives its d3 input (select 2'b11) with hi/lo results.
- Radix-2 shift-add multiply and restoring divide; multi-cycle with a start/busy/done handshake.
- The control unit stalls the PC while busy=1.

Parameters:
- WIDTH, 32, operand and result width (hi and lo are WIDTH each).
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  high from the cycle after start is accepted until the cycle done is high (inclusive).
- done  output  1  single-cycle completion pulse.
- hi  output  WIDTH  product[63:32] or remainder.
- lo  output  WIDTH  product[31:0] or quotient.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- States and transitions:
  - IDLE: on start=1, latch op, capture |a| and |b| (magnitudes for signed ops), record result signs, go to CALC with count=0.
  - CALC: one iteration per cycle; count increments; after WIDTH iterations go to FIX.
  - FIX: apply sign correction, load hi/lo, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in the following cycle, return to IDLE.
- Latency:
  - start sampled at edge E0 -> done=1 in the cycle after edge E0+WIDTH+2 (34 edges for WIDTH=32).
  - busy=1 for WIDTH+2 cycles.
- Result hold: hi/lo hold their value from FIX until the next FIX or reset; they are never X or intermediate outside CALC.
- Start handling:
  - start while busy is ignored; no queuing.
  - start in the same cycle done=1 is ignored; a new start is accepted only in IDLE.
- Multiply:
  - Unsigned 2W-bit product.
  - MULT negates the 2W product when sign(a)^sign(b).
- Divide (restoring):
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a) (truncating division).
  - Divide by zero (b=0): lo=all ones, hi=a; full latency still applies.
  - DIV overflow (a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- Operand use: a, b and op are used only at acceptance; later changes have no effect.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done pulse.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined: from IDLE, if (op is multiply and a==0 or b==0) or (op is divide and b==0), skip CALC and FIX and go directly to DONE with the architectural result:
  - multiply: hi=lo=0.
  - divide by zero: lo=all ones, hi=a.
  - done appears in the cycle after E0+1; busy=1 for 1 cycle.
- Undefined: every operation takes the full WIDTH+2 latency. Results are identical either way; only timing differs.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - state enum: IDLE, CALC, FIX, DONE.
  - constants: DIV0_QUOT (all ones), INT_MIN (0x80000000).
- Sub-module mdu_signfix (combinational): conditional two's-complement negation of a WIDTH or 2*WIDTH value.
  - Instantiated for operand magnitude capture and for FIX-stage correction.

Test Plan:
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 edges after the start edge; busy high 34 cycles.
- MULT, a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU, a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
- DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake/reset:
  - Second start at cycle 10 of a busy operation is ignored; first result is unchanged.
  - rst_n low at cycle 20 -> all outputs 0 immediately, no done pulse.
  - With MDU_EARLY_TERM_EN, MULTU a=0 -> done one cycle after acceptance, hi=lo=0.
